psa_simd_pipe: RTL and testbench
================================

PSA_SIMD_PIPE -- requirements
Module: psa_simd_pipe

Interface
REQ-001 Parameter DATA_W, default 16, total operand width in bits.
REQ-002 Parameter LANE_W, default 4, lane width in bits; DATA_W SHALL be an integer multiple of LANE_W, and LANE_W SHALL be at least 2; NLANES = DATA_W/LANE_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 A, B  input  DATA_W  packed operands.
REQ-008 mode  input  2  00 lane wrap-add, 01 lane saturating-add, 10 full-width wrap-add, 11 lane saturating-subtract (A-B).
REQ-009 out_valid  output  1  result beat valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 Sum  output  DATA_W  packed result.
REQ-012 lane_ovfl  output  NLANES  per-lane signed-overflow flags for the current result.
REQ-013 clr_err  input  1  clears the sticky error.
REQ-014 Error  output  1  sticky OR of all overflow flags on completed transfers.

Function
REQ-015 Transfers: an input transfer occurs when in_valid&in_ready; an output transfer occurs when out_valid&out_ready.
REQ-016 Pipeline: two register stages (S1 operand/mode capture, S2 result); the result appears on out_valid exactly 2 cycles after the input transfer when there is no backpressure.
REQ-017 Advance enable: adv = ~out_valid | out_ready; in_ready = adv; S1 and S2 load only when adv=1, otherwise hold all contents.
REQ-018 Bubbles: stage valid bits propagate with the data; an empty S1 loads S2 as invalid when adv=1.
REQ-019 Full throughput: with out_ready held at 1, one beat per cycle SHALL be accepted and delivered.
REQ-020 Mode 00: each lane computes A_lane+B_lane mod 2^LANE_W; no carry crosses lane boundaries.
REQ-021 Overflow: lane_ovfl[i] is signed two's-complement overflow of lane i (operands of equal sign, result of opposite sign; for subtract, the signs of A and ~B are compared).
REQ-022 Mode 01/11: an overflowed lane saturates to 0 followed by all 1s on positive overflow and to 1 followed by all 0s on negative overflow; lane_ovfl still reports the overflow.
REQ-023 Mode 10: ripple add across the full DATA_W with wrap; only lane_ovfl[NLANES-1] may be set (full-width signed overflow); other bits are 0.
REQ-024 Sum/lane_ovfl are registered in S2 and stable while out_valid&~out_ready.
REQ-025 Sticky Error: set in the cycle after an output transfer whose lane_ovfl is nonzero; cleared by clr_err; simultaneous set and clear -> set wins.
REQ-026 The mode is captured per beat in S1; changing mode never affects beats already accepted.

Reset
REQ-027 When rst=1 at a clock edge: both stage valids = 0, Sum = 0, lane_ovfl = 0, Error = 0; in-flight beats are discarded.
REQ-028 During reset, in_ready = 1 (the output is empty); beats presented while rst=1 are not captured.

Structure
REQ-029 A shared package psa_pkg SHALL hold the mode encodings (MODE_WRAP, MODE_SAT, MODE_FULL, MODE_SUBSAT) and the saturation-constant functions.
REQ-030 One sub-module psa_lane (combinational, LANE_W-parametrised add/sub, overflow, saturate) SHALL be instantiated NLANES times via generate; mode 10 uses a separate full-width adder path.

Verification
REQ-031 Default params, mode 00, A=0x7777, B=0x1111 -> Sum=0x8888, lane_ovfl=4'b1111, 2-cycle latency, Error=1 after the transfer.
REQ-032 Mode 01, same operands -> Sum=0x7777, lane_ovfl=4'b1111; mode 11, A=0x8888, B=0x1111 -> Sum=0x8888, lane_ovfl=4'b1111; mode 10, A=0x7777, B=0x1111 -> Sum=0x8888, lane_ovfl=4'b1000.
REQ-033 Backpressure: stream 5 beats with out_ready=0 for 3 cycles mid-stream -> no loss or duplication, in_ready=0 while stalled, Sum stable, order preserved.
REQ-034 Simultaneous clr_err with an overflowing transfer -> Error remains 1; clr_err alone next cycle -> Error=0.
REQ-035 Assert rst with 2 beats in flight -> out_valid=0 and Sum=0 next cycle; no stale beat emerges afterwards.
REQ-036 Params DATA_W=32, LANE_W=8, mode 00, A=0x7F010080, B=0x01FF0080 -> Sum=0x80000000, lane_ovfl=4'b1001.

Source files
------------

// File: rtl/psa_pkg.sv
// Shared definitions for the packed SIMD add pipeline.
// Holds the mode encodings and the lane saturation constants.
package psa_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_FULL   = 2'b10,
        MODE_SUBSAT = 2'b11
    } psa_mode_e;

    // Largest positive two's-complement value of width w: 0 followed by all 1s.
    function automatic logic [63:0] sat_pos(input int unsigned w);
        sat_pos = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of width w: 1 followed by all 0s.
    function automatic logic [63:0] sat_neg(input int unsigned w);
        sat_neg = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/psa_lane.sv
// One combinational SIMD lane: add or subtract, signed overflow
// detection and optional saturation.
module psa_lane
    import psa_pkg::*;
#(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  logic              sub_i,
    input  logic              sat_i,
    output logic [LANE_W-1:0] res_o,
    output logic              ovfl_o
);

    localparam int                MSB     = LANE_W - 1;
    localparam logic [LANE_W-1:0] POS_SAT = LANE_W'(sat_pos(LANE_W));
    localparam logic [LANE_W-1:0] NEG_SAT = LANE_W'(sat_neg(LANE_W));

    logic [LANE_W-1:0] b_eff;
    logic [LANE_W-1:0] raw;

    // Subtraction is A + ~B + 1, so overflow compares the signs of A and ~B.
    assign b_eff  = sub_i ? ~b_i : b_i;
    assign raw    = a_i + b_eff + {{(LANE_W-1){1'b0}}, sub_i};
    assign ovfl_o = (a_i[MSB] == b_eff[MSB]) && (raw[MSB] != a_i[MSB]);

    always_comb begin
        res_o = raw;
        if (sat_i && ovfl_o) begin
            res_o = a_i[MSB] ? NEG_SAT : POS_SAT;
        end
    end

endmodule

// File: rtl/psa_simd_pipe.sv
// Two-stage valid/ready pipeline performing packed per-lane add/sub
// (wrap or saturating) or a full-width add, with a sticky overflow flag.
module psa_simd_pipe
    import psa_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          A,
    input  logic [DATA_W-1:0]          B,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          Sum,
    output logic [DATA_W/LANE_W-1:0]   lane_ovfl,
    input  logic                       clr_err,
    output logic                       Error
);

    localparam int NLANES = DATA_W / LANE_W;

    // S1: operand and mode capture
    logic              s1_valid_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    psa_mode_e         mode_q;

    // S2: registered result
    logic              s2_valid_q;
    logic [DATA_W-1:0] sum_q;
    logic [NLANES-1:0] ovfl_q;
    logic              err_q;

    logic              adv;
    logic              lane_sub;
    logic              lane_sat;
    logic [DATA_W-1:0] lane_res;
    logic [NLANES-1:0] lane_ovfl_w;
    logic [DATA_W-1:0] full_sum;
    logic              full_ovfl;
    logic [DATA_W-1:0] sum_d;
    logic [NLANES-1:0] ovfl_d;

    assign adv      = ~s2_valid_q | out_ready;
    // The output stage is already empty while reset is held, so report ready.
    assign in_ready = rst | adv;

    assign lane_sub = (mode_q == MODE_SUBSAT);
    assign lane_sat = (mode_q == MODE_SAT) || (mode_q == MODE_SUBSAT);

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            psa_lane #(
                .LANE_W (LANE_W)
            ) u_lane (
                .a_i    (a_q[gi*LANE_W +: LANE_W]),
                .b_i    (b_q[gi*LANE_W +: LANE_W]),
                .sub_i  (lane_sub),
                .sat_i  (lane_sat),
                .res_o  (lane_res[gi*LANE_W +: LANE_W]),
                .ovfl_o (lane_ovfl_w[gi])
            );
        end
    endgenerate

    // Full-width path lets the carry ripple through every lane boundary.
    assign full_sum  = a_q + b_q;
    assign full_ovfl = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                       (full_sum[DATA_W-1] != a_q[DATA_W-1]);

    always_comb begin
        sum_d  = lane_res;
        ovfl_d = lane_ovfl_w;
        if (mode_q == MODE_FULL) begin
            sum_d              = full_sum;
            ovfl_d             = '0;
            ovfl_d[NLANES-1]   = full_ovfl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= MODE_WRAP;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            ovfl_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    a_q    <= A;
                    b_q    <= B;
                    mode_q <= psa_mode_e'(mode);
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q  <= sum_d;
                    ovfl_q <= ovfl_d;
                end
            end
            // A new overflow outranks a same-cycle clear.
            if (s2_valid_q && out_ready && (|ovfl_q)) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign Sum       = sum_q;
    assign lane_ovfl = ovfl_q;
    assign Error     = err_q;

endmodule

// File: tb/tb_psa_simd_pipe.sv
// Directed self-checking bench for psa_simd_pipe (16/4 default and 32/8).
module tb_psa_simd_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic [3:0]  lane_ovfl;
    logic        clr_err;
    logic        Error;

    logic        in32_valid;
    logic        in32_ready;
    logic [31:0] A32;
    logic [31:0] B32;
    logic [1:0]  mode32;
    logic        out32_valid;
    logic        out32_ready;
    logic [31:0] Sum32;
    logic [3:0]  ovfl32;
    logic        err32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psa_simd_pipe u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .lane_ovfl (lane_ovfl),
        .clr_err   (clr_err),
        .Error     (Error)
    );

    psa_simd_pipe #(
        .DATA_W (32),
        .LANE_W (8)
    ) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in32_valid),
        .in_ready  (in32_ready),
        .A         (A32),
        .B         (B32),
        .mode      (mode32),
        .out_valid (out32_valid),
        .out_ready (out32_ready),
        .Sum       (Sum32),
        .lane_ovfl (ovfl32),
        .clr_err   (1'b0),
        .Error     (err32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat through an empty pipe with out_ready=1: checks latency,
    // result, flags and the sticky error after the output transfer.
    task automatic send_one(input string tag, input logic [1:0] m,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_sum, input logic [3:0] exp_ov,
                            input logic exp_err, input logic clr);
        clr_err   = clr;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mode      = m;
        A         = a;
        B         = b;
        step();
        check({tag, "_lat1"}, out_valid, 1'b0);
        in_valid = 1'b0;
        mode     = ~m;
        A        = 16'hFFFF;
        B        = 16'h0000;
        step();
        check({tag, "_vld"}, out_valid, 1'b1);
        check({tag, "_sum"}, Sum, exp_sum);
        check({tag, "_ovf"}, lane_ovfl, exp_ov);
        step();
        check({tag, "_err"}, Error, exp_err);
        check({tag, "_drain"}, out_valid, 1'b0);
        clr_err = 1'b0;
    endtask

    task automatic clear_err(input string tag);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check(tag, Error, 1'b0);
    endtask

    logic [15:0] sa [5] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
    logic [15:0] se [5] = '{16'h1111, 16'h1212, 16'h1313, 16'h1414, 16'h1515};

    initial begin
        int          in_idx;
        int          out_idx;
        logic [15:0] held;
        logic        held_ok;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; mode = 2'b00;
        out_ready = 1'b1; clr_err = 1'b0;
        in32_valid = 1'b0; A32 = '0; B32 = '0; mode32 = 2'b00; out32_ready = 1'b1;
        step();
        step();
        check("rst_rdy", in_ready, 1'b1);
        check("rst_vld", out_valid, 1'b0);
        check("rst_sum", Sum, 16'h0000);
        check("rst_ovf", lane_ovfl, 4'h0);
        check("rst_err", Error, 1'b0);
        rst = 1'b0;
        step();

        send_one("w_ovf",   2'b00, 16'h7777, 16'h1111, 16'h8888, 4'hF, 1'b1, 1'b0);
        clear_err("clr1");
        send_one("w_plain", 2'b00, 16'h1234, 16'h1111, 16'h2345, 4'h0, 1'b0, 1'b0);
        send_one("w_iso",   2'b00, 16'h00FF, 16'h0001, 16'h00F0, 4'h0, 1'b0, 1'b0);
        send_one("f_carry", 2'b10, 16'h00FF, 16'h0001, 16'h0100, 4'h0, 1'b0, 1'b0);
        send_one("s_pos",   2'b01, 16'h7777, 16'h1111, 16'h7777, 4'hF, 1'b1, 1'b0);
        send_one("s_mix",   2'b01, 16'h7180, 16'h1188, 16'h7288, 4'hA, 1'b1, 1'b0);
        send_one("ss_neg",  2'b11, 16'h8888, 16'h1111, 16'h8888, 4'hF, 1'b1, 1'b0);
        send_one("ss_pos",  2'b11, 16'h7000, 16'h8000, 16'h7000, 4'h8, 1'b1, 1'b0);
        send_one("f_ovf",   2'b10, 16'h7777, 16'h1111, 16'h8888, 4'h8, 1'b1, 1'b0);
        clear_err("clr2");
        send_one("setwin",  2'b00, 16'h7777, 16'h1111, 16'h8888, 4'hF, 1'b1, 1'b1);
        clear_err("clr3");

        // Stream with a 3-cycle output stall in the middle.
        in_idx  = 0;
        out_idx = 0;
        held    = '0;
        held_ok = 1'b0;
        mode    = 2'b00;
        B       = 16'h1010;
        for (int c = 0; c < 40 && out_idx < 5; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (in_idx < 5);
            if (in_idx < 5) A = sa[in_idx];
            @(negedge clk);
            if (out_valid && !out_ready) begin
                check("bp_rdy", in_ready, 1'b0);
                if (held_ok) check("bp_hold", Sum, held);
                held    = Sum;
                held_ok = 1'b1;
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_out%0d", out_idx), Sum, se[out_idx]);
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_nin", in_idx, 5);
        check("bp_nout", out_idx, 5);
        check("bp_stalled", held_ok, 1'b1);
        step();
        check("bp_nodup", out_valid, 1'b0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 16'h7777; B = 16'h1111;
        step();
        A = 16'h1234; B = 16'h1111;
        step();
        check("rf_pre", out_valid, 1'b1);
        rst = 1'b1;
        A   = 16'h0101;
        #1;
        check("rf_rdy", in_ready, 1'b1);
        step();
        check("rf_vld", out_valid, 1'b0);
        check("rf_sum", Sum, 16'h0000);
        check("rf_ovf", lane_ovfl, 4'h0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rf_stale%0d", k), out_valid, 1'b0);
        end

        // 32-bit / 8-bit lane configuration.
        in32_valid = 1'b1;
        mode32     = 2'b00;
        A32        = 32'h7F010080;
        B32        = 32'h01FF0080;
        step();
        in32_valid = 1'b0;
        step();
        check("w32_vld", out32_valid, 1'b1);
        check("w32_sum", Sum32, 32'h80000000);
        check("w32_ovf", ovfl32, 4'b1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
